// File: rtl/psum_ofifo.sv
// ---------------------------------------------------------------------------
// psum_ofifo
//
// Collects the partial sums that leave the south edge of the systolic MAC
// array. There is one FIFO lane per array column. Each lane is written on its
// own valid strobe, which absorbs the diagonal skew between columns. The
// downstream reader pops one aligned row of `col` psums at a time, and only
// once every lane holds data.
//
// Ports
//   clk        : clock; all state changes on posedge
//   reset      : synchronous, active-high; clears pointers and o_overflow
//   in         : south psums; column c is in[psum_bw*(c+1)-1 : psum_bw*c]
//   wr         : per-column write strobe (the array's valid bus)
//   rd         : pop request for one full row
//   out        : head entry of every lane, packed the same way as `in`
//   o_valid    : every lane is non-empty
//   o_full     : at least one lane is full
//   o_ready    : ~o_full
//   o_overflow : sticky; set when a write was dropped on a full lane
//
// Handshake: a row transfers on any posedge where rd && o_valid. Writes are
// per lane. A write to lane c is taken when that lane is not full, or when a
// row pop happens on the same edge. If wr[c] arrives while lane c is full and
// no pop happens on that edge, the word is dropped and o_overflow is set.
// o_ready is only advisory for the array side.
// ---------------------------------------------------------------------------
module psum_ofifo #(
    parameter int psum_bw = 16,
    parameter int col     = 4,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

    // The pointers carry one extra wrap bit. This lets full and empty be told
    // apart when the low address bits are equal.
    logic [aw:0]         wr_ptr [col];
    logic [aw:0]         rd_ptr [col];
    logic [psum_bw-1:0]  mem    [col][depth];

    logic [col-1:0] lane_empty;
    logic [col-1:0] lane_full;
    logic [col-1:0] wr_en;
    logic [col-1:0] wr_drop;
    logic           pop;

    always_comb begin
        lane_empty = '0;
        lane_full  = '0;
        out        = '0;
        for (int c = 0; c < col; c++) begin
            lane_empty[c] = (wr_ptr[c] == rd_ptr[c]);
            lane_full[c]  = (wr_ptr[c][aw-1:0] == rd_ptr[c][aw-1:0]) &&
                            (wr_ptr[c][aw] != rd_ptr[c][aw]);
            // First-word-fall-through: the head entry is always presented.
            out[c*psum_bw +: psum_bw] = mem[c][rd_ptr[c][aw-1:0]];
        end
    end

    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A full lane can still take a write when a row pop happens on the same
    // edge. The pop frees the old head, so the occupancy stays the same.
    assign wr_en   = wr & (~lane_full | {col{pop}});
    assign wr_drop = wr & lane_full & ~{col{pop}};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            o_overflow <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + ptr_one;
                if (pop)      rd_ptr[c] <= rd_ptr[c] + ptr_one;
            end
            if (|wr_drop) o_overflow <= 1'b1;
        end
    end

    // Storage is not reset. Entries are only observed after they are written.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (wr_en[c]) mem[c][wr_ptr[c][aw-1:0]] <= in[c*psum_bw +: psum_bw];
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// ---------------------------------------------------------------------------
// tb_psum_ofifo
//
// Directed bench for psum_ofifo with psum_bw=16, col=4, depth=8.
// Inputs change 1 time unit after each posedge. Outputs are sampled at the
// same point, once the edge's updates have settled.
// ---------------------------------------------------------------------------
module tb_psum_ofifo;

    localparam int psum_bw = 16;
    localparam int col     = 4;
    localparam int depth   = 8;
    localparam int w       = psum_bw * col;

    logic           clk = 1'b0;
    logic           reset;
    logic [w-1:0]   in;
    logic [col-1:0] wr;
    logic           rd;
    logic [w-1:0]   out;
    logic           o_valid;
    logic           o_full;
    logic           o_ready;
    logic           o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    psum_ofifo #(.psum_bw(psum_bw), .col(col), .depth(depth)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .wr         (wr),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [w-1:0] obs, input logic [w-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check all four flags at once: {o_valid, o_full, o_ready, o_overflow}.
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {{(w-4){1'b0}}, o_valid, o_full, o_ready, o_overflow}, {{(w-4){1'b0}}, exp});
    endtask

    // Drive one cycle of inputs, then return 1 unit after the edge.
    task automatic cyc(input logic [col-1:0] w_s, input logic [w-1:0] d, input logic r);
        wr = w_s;
        in = d;
        rd = r;
        @(posedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc('0, '0, 1'b0);
        reset = 1'b0;
    endtask

    function automatic logic [w-1:0] rep(input logic [psum_bw-1:0] v);
        return {col{v}};
    endfunction

    // Wrap pattern: lane c of step i holds i*16 + c.
    function automatic logic [w-1:0] pat(input int i);
        logic [w-1:0] r;
        for (int c = 0; c < col; c++) r[c*psum_bw +: psum_bw] = 16'(i * 16 + c);
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        in    = '0;
        wr    = '0;
        rd    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset and idle. The flag order is valid, full, ready, ovf.
        chk_flags("reset_flags", 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cyc('0, '0, 1'b1);
            chk_flags("idle_rd_flags", 4'b0010);
        end

        // Skewed fill: each column arrives one cycle after the previous one.
        cyc(4'b0001, 64'h0044_0033_0022_0011, 1'b0);
        chk_flags("skew_c0", 4'b0010);
        cyc(4'b0010, 64'h0044_0033_0022_0011, 1'b0);
        chk_flags("skew_c1", 4'b0010);
        cyc(4'b0100, 64'h0044_0033_0022_0011, 1'b0);
        chk_flags("skew_c2", 4'b0010);
        cyc(4'b1000, 64'h0044_0033_0022_0011, 1'b0);
        chk_flags("skew_c3", 4'b1010);
        chk("skew_out", out, 64'h0044_0033_0022_0011);
        cyc('0, '0, 1'b1);
        chk_flags("skew_pop", 4'b0010);

        // Fill to depth with k*0x101, overflow once, then drain.
        for (int k = 0; k < depth; k++) cyc(4'b1111, rep(16'(k * 16'h0101)), 1'b0);
        chk_flags("fill_full", 4'b1100);
        chk("fill_head", out, rep(16'h0000));
        cyc(4'b1111, rep(16'hFFFF), 1'b0);
        chk_flags("overflow_set", 4'b1101);
        chk("overflow_head", out, rep(16'h0000));
        for (int k = 0; k < depth; k++) begin
            chk("drain_out", out, rep(16'(k * 16'h0101)));
            cyc('0, '0, 1'b1);
        end
        chk_flags("drain_empty_ovf_sticky", 4'b0011);
        do_reset();
        chk_flags("reset_clears_ovf", 4'b0010);

        // Full lanes with a write and a pop on the same edge.
        for (int k = 0; k < depth; k++) cyc(4'b1111, rep(16'(k * 16'h0101)), 1'b0);
        cyc(4'b1111, rep(16'hAAAA), 1'b1);
        chk_flags("full_rdwr_flags", 4'b1100);
        chk("full_rdwr_out", out, rep(16'h0101));
        for (int k = 1; k < depth; k++) begin
            chk("full_rdwr_drain", out, rep(16'(k * 16'h0101)));
            cyc('0, '0, 1'b1);
        end
        chk("full_rdwr_last", out, rep(16'hAAAA));
        cyc('0, '0, 1'b1);
        chk_flags("full_rdwr_empty", 4'b0010);

        // Continuous streaming across pointer wrap.
        cyc(4'b1111, pat(0), 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cyc(4'b1111, pat(i), 1'b1);
            chk("wrap_out", out, pat(i));
            chk_flags("wrap_flags", 4'b1010);
        end
        cyc('0, '0, 1'b1);
        chk_flags("wrap_empty", 4'b0010);

        // One lane full on its own: o_full rises, no row is valid, and a
        // further write to that lane is dropped.
        for (int k = 0; k < depth; k++) cyc(4'b0001, rep(16'(k)), 1'b0);
        chk_flags("lane0_full", 4'b0100);
        cyc(4'b0001, rep(16'h1234), 1'b1);
        chk_flags("lane0_drop", 4'b0101);
        do_reset();

        // Reset while lanes hold data.
        for (int k = 0; k < 5; k++) cyc(4'b1111, rep(16'(16'h0500 + k)), 1'b0);
        chk_flags("five_valid", 4'b1010);
        chk("five_head", out, rep(16'h0500));
        do_reset();
        chk_flags("reset_mid", 4'b0010);
        cyc(4'b1111, rep(16'hBEEF), 1'b0);
        chk_flags("beef_flags", 4'b1010);
        chk("beef_out", out, rep(16'hBEEF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Per-column output FIFO that collects partial sums leaving the south edge of the systolic MAC array.
- Each column writes independently on its own valid strobe, which absorbs the diagonal column skew of the array.
- A downstream reader (psum SRAM writer / SFU) pops one full aligned row of `col` psums at a time, once every column holds data.

Parameters:
- psum_bw, 16, width of one partial sum.
- col, 4, number of array columns, i.e. independent FIFO lanes.
- depth, 8, entries per column lane; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all pointers and flags.
- in  input  psum_bw*col  south psums from the array; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
- wr  input  col  per-column write strobe, driven by the array's valid bus.
- rd  input  1  pop request for one full row.
- out  output  psum_bw*col  head entry of every lane, same column packing as in.
- o_valid  output  1  every lane is non-empty.
- o_full  output  1  at least one lane is full.
- o_ready  output  1  equals ~o_full.
- o_overflow  output  1  sticky flag: a write was dropped on a full lane.

Behaviour:
- Storage per lane: depth x psum_bw register file.
- Pointers per lane: wr_ptr and rd_ptr, each log2(depth)+1 bits with an extra wrap bit.
  - Lane empty when wr_ptr == rd_ptr.
  - Lane full when the low bits are equal and the wrap bits differ.
- Reset (any cycle, including mid-operation): all pointers go to 0 and o_overflow goes to 0 on the next edge.
  - Resulting outputs: o_valid=0, o_full=0, o_ready=1.
  - out = contents of entry 0 (don't-care; the bench must not check it).
  - Storage contents are not cleared.
- Write: when wr[c]=1 at a posedge and lane c is not full, or is full but is popped in the same cycle:
  - mem[c][wr_ptr] <= in slice c;
  - wr_ptr[c] increments and wraps modulo 2*depth.
- Dropped write: when wr[c]=1, lane c is full, and there is no same-cycle pop:
  - the write is dropped, no pointer moves;
  - o_overflow <= 1 and stays set until reset.
- Pop: accepted when rd=1 and o_valid=1 at a posedge.
  - Every lane's rd_ptr increments together.
  - rd while o_valid=0 is ignored: no pointer moves and no error flag is raised.
- Simultaneous rd and wr on one lane:
  - Both take effect; occupancy is unchanged.
  - The pop removes the old head, not the incoming word.
- out is first-word-fall-through: combinational from each lane's current rd_ptr entry.
  - out is meaningful only while o_valid=1.
  - After an accepted pop, out shows the next entries in the following cycle.
- Write-to-read latency: data written at edge N is visible on out, with o_valid asserted, after edge N, provided all other lanes are already non-empty.
- o_valid, o_full and o_ready are combinational from the pointers; no bypass from in to out.
- Lanes are independent for writes, so they may hold different occupancies; reads are always row-aligned.
- Pointer wrap: 2*depth writes and reads in sequence return the pointers to their start value with no data corruption.

Test Plan:
- Reset, then idle:
  - o_valid=0, o_full=0, o_ready=1, o_overflow=0.
  - rd=1 for 3 cycles leaves the state unchanged.
- Skewed fill:
  - Stimulus: wr=0001 at cycle 0 (col0=0x0011), wr=0010 at cycle 1 (0x0022), wr=0100 at cycle 2 (0x0033), wr=1000 at cycle 3 (0x0044).
  - o_valid stays 0 until after cycle 3, then out=0x0044_0033_0022_0011.
  - One rd returns o_valid=0.
- Fill all lanes to 8 entries with values k*0x101 (k=0..7):
  - o_full=1 and o_ready=0.
  - A further wr=1111 sets o_overflow=1 and does not change the data.
  - 8 rd pops return k*0x101 in order in every lane.
- Full lanes with wr=1111 and rd=1 in the same cycle:
  - Both accepted; o_overflow stays 0; o_full stays 1.
  - Next out = the second-oldest entry.
- Wrap: 20 cycles of continuous wr=1111 and rd=1 with an incrementing pattern (after a one-entry prefill):
  - out always equals the value written one pop earlier; no flag asserts.
- Reset with 5 entries per lane:
  - Next cycle o_valid=0 and o_overflow=0.
  - A new write of 0xBEEF to all lanes reads back 0xBEEF.
